wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter.
// Merges in-order pipeline writebacks with buffered long-latency (mul/div)
// results. The pipeline normally has priority. A buffered result that waits
// STARVE_LIMIT cycles forces its way in by stalling the pipeline for one cycle.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_valid,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  output logic                     pipe_stall,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     rf_we,
  output logic [4:0]               rf_rd_addr,
  output logic [31:0]              rf_wdata,
  output logic [31:0]              pending_mask,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    SLIM    = 4'(STARVE_LIMIT);

  // Buffer storage; a valid bit per slot drives pending_mask directly
  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [3:0]       starve_cnt;

  logic buf_empty, pipe_req, starved, enq;
  logic grant_buf, grant_pipe;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign buf_empty = (buf_count == '0);
  // A write to x0 is architecturally a no-op, so it never competes for the port
  assign pipe_req  = pipe_valid && (pipe_rd != 5'd0);
  assign starved   = (starve_cnt == SLIM) && !buf_empty;
  // Ready looks only at state and reset, never at the offered request
  assign mdu_ready = (buf_count < DEPTH_C) && !rst;
  assign enq       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
  assign head_rd   = ent_rd[rd_ptr];
  assign head_data = ent_data[rd_ptr];
  assign pipe_stall = pipe_req && grant_buf;

  // Grant selection: starved head first, then pipeline, then any buffered head.
  // Decisions use registered occupancy, so an entry accepted this edge cannot
  // be granted until the following one.
  always_comb begin
    grant_buf  = 1'b0;
    grant_pipe = 1'b0;
    if (starved)         grant_buf  = 1'b1;
    else if (pipe_req)   grant_pipe = 1'b1;
    else if (!buf_empty) grant_buf  = 1'b1;
  end

  // OR together the destination of every live entry; duplicates keep the bit
  // set until the last one retires
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) pending_mask[ent_rd[i]] = 1'b1;
  end

  // Entry payload capture; contents are only meaningful while the slot is valid
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_rd[wr_ptr]   <= mdu_rd;
      ent_data[wr_ptr] <= mdu_data;
    end
  end

  // FIFO control: pointers wrap naturally because DEPTH is a power of two.
  // Enqueue and dequeue never hit the same slot (that needs empty or full).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      ent_vld   <= '0;
      buf_count <= '0;
    end else begin
      if (grant_buf) begin
        ent_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (enq) begin
        ent_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({enq, grant_buf})
        2'b10:   buf_count <= buf_count + 1'b1;
        2'b01:   buf_count <= buf_count - 1'b1;
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Starvation counter: counts cycles the head is passed over, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        starve_cnt <= '0;
    else if (buf_empty || grant_buf) starve_cnt <= '0;
    else if (starve_cnt != SLIM)    starve_cnt <= starve_cnt + 1'b1;
  end

  // Registered write port; address/data hold when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_we <= grant_buf || grant_pipe;
      if (grant_buf) begin
        rf_rd_addr <= head_rd;
        rf_wdata   <= head_data;
      end else if (grant_pipe) begin
        rf_rd_addr <= pipe_rd;
        rf_wdata   <= pipe_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with default parameters (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_mask;
  logic [1:0]  buf_count;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
    .pending_mask(pending_mask), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_valid = v; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mdu_valid = v; mdu_rd = rd; mdu_data = d;
  endtask

  initial begin
    rst = 1'b1;
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    tick(); tick();
    chk("rst_count",   32'(buf_count), 0);
    chk("rst_we",      32'(rf_we), 0);
    chk("rst_addr",    32'(rf_rd_addr), 0);
    chk("rst_data",    rf_wdata, 0);
    chk("rst_pending", pending_mask, 0);
    chk("rst_stall",   32'(pipe_stall), 0);
    chk("rst_ready",   32'(mdu_ready), 0);
    rst = 1'b0; #1;
    chk("rel_ready",   32'(mdu_ready), 1);

    // Pipeline-only write
    pipe(1, 5, 32'h11); #1;
    chk("p_stall", 32'(pipe_stall), 0);
    tick(); pipe(0, 0, 0);
    chk("p_we",   32'(rf_we), 1);
    chk("p_addr", 32'(rf_rd_addr), 5);
    chk("p_data", rf_wdata, 32'h11);
    tick();
    chk("idle_we",   32'(rf_we), 0);
    chk("idle_addr", 32'(rf_rd_addr), 5);
    chk("idle_data", rf_wdata, 32'h11);

    // Buffer drain: two cycles from accept to rf write
    mdu(1, 7, 32'hAB);
    tick(); mdu(0, 0, 0);
    chk("d_count", 32'(buf_count), 1);
    chk("d_pend",  pending_mask, 32'h80);
    chk("d_we0",   32'(rf_we), 0);
    tick();
    chk("d_we",    32'(rf_we), 1);
    chk("d_addr",  32'(rf_rd_addr), 7);
    chk("d_data",  rf_wdata, 32'hAB);
    chk("d_pend0", pending_mask, 0);

    // Fill with continuous pipe writes, then starvation forces the head in
    pipe(1, 3, 32'h33);
    mdu(1, 9, 32'h90);
    tick();                                        // E1: accept rd9, pipe writes
    chk("f1_addr",  32'(rf_rd_addr), 3);
    chk("f1_count", 32'(buf_count), 1);
    mdu(1, 10, 32'hA0);
    tick();                                        // E2: accept rd10, starve=1
    chk("f2_count", 32'(buf_count), 2);
    chk("f2_ready", 32'(mdu_ready), 0);
    chk("f2_pend",  pending_mask, 32'h600);
    mdu(1, 11, 32'hB0);
    tick();                                        // starve=2
    chk("f3_count", 32'(buf_count), 2);
    tick();                                        // starve=3
    chk("f4_stall", 32'(pipe_stall), 0);
    tick();                                        // starve=4
    chk("f5_stall", 32'(pipe_stall), 1);
    chk("f5_addr",  32'(rf_rd_addr), 3);
    chk("f5_ready", 32'(mdu_ready), 0);
    tick();                                        // head rd9 written
    chk("f6_we",    32'(rf_we), 1);
    chk("f6_addr",  32'(rf_rd_addr), 9);
    chk("f6_data",  rf_wdata, 32'h90);
    chk("f6_count", 32'(buf_count), 1);
    chk("f6_stall", 32'(pipe_stall), 0);
    chk("f6_ready", 32'(mdu_ready), 1);
    tick();                                        // pipe follows, rd11 accepted
    chk("f7_addr",  32'(rf_rd_addr), 3);
    chk("f7_count", 32'(buf_count), 2);
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    tick();
    chk("f8_addr",  32'(rf_rd_addr), 10);
    chk("f8_data",  rf_wdata, 32'hA0);
    tick();
    chk("f9_addr",  32'(rf_rd_addr), 11);
    chk("f9_data",  rf_wdata, 32'hB0);
    chk("f9_count", 32'(buf_count), 0);
    chk("f9_pend",  pending_mask, 0);

    // x0 requests are ignored on both sides
    pipe(1, 0, 32'h55);
    mdu(1, 0, 32'h66); #1;
    chk("x0_stall", 32'(pipe_stall), 0);
    tick();
    chk("x0_we1",    32'(rf_we), 0);
    chk("x0_count1", 32'(buf_count), 0);
    tick();
    chk("x0_we2",    32'(rf_we), 0);
    chk("x0_count2", 32'(buf_count), 0);
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    tick();

    // Duplicate destination retires in order; simultaneous enq/deq
    mdu(1, 4, 32'h1);
    tick();
    mdu(1, 4, 32'h2);
    tick(); mdu(0, 0, 0);
    chk("dup_data1", rf_wdata, 32'h1);
    chk("dup_count", 32'(buf_count), 1);
    chk("dup_pend",  pending_mask, 32'h10);
    tick();
    chk("dup_data2", rf_wdata, 32'h2);
    chk("dup_pend0", pending_mask, 0);

    // Reset with a full buffer discards everything
    pipe(1, 3, 32'h33);
    mdu(1, 20, 32'h200);
    tick();
    mdu(1, 21, 32'h210);
    tick();
    chk("r_count_full", 32'(buf_count), 2);
    rst = 1'b1; #1;
    chk("r_count", 32'(buf_count), 0);
    chk("r_pend",  pending_mask, 0);
    chk("r_we",    32'(rf_we), 0);
    chk("r_addr",  32'(rf_rd_addr), 0);
    chk("r_stall", 32'(pipe_stall), 0);
    chk("r_ready", 32'(mdu_ready), 0);
    pipe(0, 0, 0);
    mdu(0, 0, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_post_we", 32'(rf_we), 0);
    end
    chk("r_post_count", 32'(buf_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
